fetch_debug_ctrl: RTL and testbench

//  Byte-command controller for the fetch stage. Consumes UART receive bytes, assembles 32-bit words,

---
 rtl/fetch_debug_ctrl_pkg.sv | 22 ++
 rtl/fetch_debug_ctrl_if.sv | 29 ++
 rtl/fetch_debug_ctrl_word_assembler.sv | 56 +++++
 rtl/fetch_debug_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fetch_debug_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_debug_ctrl_pkg.sv
// Shared definitions for the fetch-stage debug controller: FSM state
// encoding, ASCII command bytes and the default halt word.
// Optional feature macro used by the design: LOAD_CHECKSUM_EN.
package fetch_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHK   = 3'd2,
        ARMED = 3'd3,
        RUN   = 3'd4,
        STEP  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_debug_ctrl_if.sv
// Bus between the debug controller and its environment: UART receive
// bytes and halt flag in, instruction-memory write port and execution
// control out. The controller takes the slave side.
interface fetch_debug_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_rx_valid;
    logic [7:0]            i_rx_data;
    logic                  i_haltsignal;
    logic                  o_loading;
    logic [DATA_WIDTH-1:0] o_instruccion;
    logic [DATA_WIDTH-1:0] o_address;
    logic                  o_start;
    logic                  o_step;
    logic                  o_done;
    logic                  o_error;

    modport master (
        output i_rx_valid, i_rx_data, i_haltsignal,
        input  o_loading, o_instruccion, o_address,
        input  o_start, o_step, o_done, o_error
    );

    modport slave (
        input  i_rx_valid, i_rx_data, i_haltsignal,
        output o_loading, o_instruccion, o_address,
        output o_start, o_step, o_done, o_error
    );
endinterface

// File: rtl/fetch_debug_ctrl_word_assembler.sv
// Packs received bytes MSB-first into words. word_valid is asserted in the
// same cycle as the last byte of a word, with word carrying the complete
// value, so the owner can register it on that edge.
// With LOAD_CHECKSUM_EN defined it also keeps a running XOR of every byte.
module word_assembler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [7:0]            xor_acc
`endif
);
    localparam int BYTES = DATA_WIDTH / 8;

    // Only the bytes before the last one need storing; the last byte is
    // taken straight from the input when the word completes.
    logic [DATA_WIDTH-9:0] shift_reg;
    logic [1:0]            byte_cnt_reg;

    assign word       = {shift_reg, in_data};
    assign word_valid = in_valid && (byte_cnt_reg == 2'(BYTES - 1));

    // Shift register and byte counter; the counter wraps at the word boundary.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
        end else if (in_valid) begin
            shift_reg    <= word[DATA_WIDTH-9:0];
            byte_cnt_reg <= (byte_cnt_reg == 2'(BYTES - 1)) ? 2'd0 : byte_cnt_reg + 2'd1;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] xor_acc_reg;

    assign xor_acc = xor_acc_reg;

    // Running XOR of every byte of the current load.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            xor_acc_reg <= '0;
        end else if (in_valid) begin
            xor_acc_reg <= xor_acc_reg ^ in_data;
        end
    end
`endif

endmodule

// File: rtl/fetch_debug_ctrl.sv
// Byte-command controller for the fetch stage: loads a program from UART
// bytes into instruction memory, then runs it freely ('C') or single-steps
// it ('S' followed by 'N' bytes) until the fetch stage reports halt.
// Optional feature macro: LOAD_CHECKSUM_EN (a checksum byte follows the halt word).
module fetch_debug_ctrl
    import fetch_dbg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
    input  logic                i_clock,
    input  logic                i_reset,
    fetch_debug_ctrl_if.slave   bus
);
    localparam int CW = $clog2(MEM_DEPTH + 1);

    state_t                state_reg, state_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  loading_reg, loading_next;
    logic [DATA_WIDTH-1:0] instr_reg, instr_next;
    logic [DATA_WIDTH-1:0] addr_reg, addr_next;
    logic                  start_reg, start_next;
    logic                  step_reg, step_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;

    logic                  asm_clear;
    logic                  asm_valid;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic [CW-1:0]         count_inc;
`ifdef LOAD_CHECKSUM_EN
    logic [7:0]            xor_acc;
`endif

    // Bytes only reach the assembler while a program is being loaded.
    assign asm_valid = bus.i_rx_valid && (state_reg == LOAD);
    assign count_inc = count_reg + CW'(1);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clk        (i_clock),
        .srst       (i_reset),
        .clear      (asm_clear),
        .in_valid   (asm_valid),
        .in_data    (bus.i_rx_data),
        .word_valid (word_valid),
        .word       (word)
`ifdef LOAD_CHECKSUM_EN
        ,
        .xor_acc    (xor_acc)
`endif
    );

    // State and output registers; reset overrides everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            loading_reg <= 1'b0;
            instr_reg   <= '0;
            addr_reg    <= '0;
            start_reg   <= 1'b0;
            step_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            loading_reg <= loading_next;
            instr_reg   <= instr_next;
            addr_reg    <= addr_next;
            start_reg   <= start_next;
            step_reg    <= step_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
        end
    end

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        loading_next = 1'b0;
        instr_next   = instr_reg;
        addr_next    = addr_reg;
        start_next   = start_reg;
        step_next    = 1'b0;
        done_next    = done_reg;
        error_next   = error_reg;
        asm_clear    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        state_next = LOAD;
                        done_next  = 1'b0;
                        error_next = 1'b0;
                        count_next = '0;
                        asm_clear  = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (word_valid) begin
                    loading_next = 1'b1;
                    instr_next   = word;
                    addr_next    = DATA_WIDTH'({count_reg, 2'b00});
                    count_next   = count_inc;
                    // The halt word is still written; it also ends the load,
                    // even when it lands in the very last memory slot.
                    if (word == HALT_WORD) begin
`ifdef LOAD_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = ARMED;
`endif
                    end else if (count_inc == CW'(MEM_DEPTH)) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            CHK: begin
`ifdef LOAD_CHECKSUM_EN
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == xor_acc) begin
                        state_next = ARMED;
                    end else begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end

            ARMED: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_CONT) begin
                        state_next = RUN;
                        start_next = 1'b1;
                    end else if (bus.i_rx_data == CMD_STEP) begin
                        state_next = STEP;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end

            // Bytes are ignored while free-running; only halt or reset ends it.
            RUN: begin
                if (bus.i_haltsignal) begin
                    start_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            // Halt has priority over a coincident 'N'.
            STEP: begin
                if (bus.i_haltsignal) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (bus.i_rx_valid && (bus.i_rx_data == CMD_NEXT)) begin
                    step_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_loading     = loading_reg;
    assign bus.o_instruccion = instr_reg;
    assign bus.o_address     = addr_reg;
    assign bus.o_start       = start_reg;
    assign bus.o_step        = step_reg;
    assign bus.o_done        = done_reg;
    assign bus.o_error       = error_reg;

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Self-checking bench for fetch_debug_ctrl (MEM_DEPTH reduced to 4 so the
// overflow and last-slot cases are reachable). Expected behaviour comes from
// a program-level model: which words get written where, whether the load
// ends armed or in error, and how many step pulses a byte stream yields.
module tb_fetch_debug_ctrl;
    import fetch_dbg_pkg::*;

    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_debug_ctrl_if #(.DATA_WIDTH(DW)) bus();

    fetch_debug_ctrl #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .HALT_WORD  (HALT)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Event counters sampled just after every active edge.
    int   step_pulses = 0;
    int   step_cycles = 0;
    int   load_count  = 0;
    logic step_prev   = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.o_step) step_cycles++;
        if (bus.o_step && !step_prev) step_pulses++;
        step_prev = bus.o_step;
        if (bus.o_loading) load_count++;
    end

    logic [31:0] prog_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte per call, valid for exactly one cycle; returns at the negedge
    // after the consuming edge so registered effects are visible.
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        return $urandom() & 32'hFFFF_FFFE;   // never the halt word
    endfunction

    // Build prog_q: n ordinary words followed by the halt word.
    task automatic make_prog(input int n);
        prog_q.delete();
        for (int i = 0; i < n; i++) prog_q.push_back(rand_word());
        prog_q.push_back(HALT);
    endtask

    // Load prog_q and check it against the model. Model: words are written
    // to consecutive word slots until the halt word (inclusive) or until the
    // memory is full; the load arms only if the halt word fitted (and, with a
    // checksum, if the checksum byte matched the XOR of all data bytes).
    task automatic run_load(input bit good_sum, output bit armed);
        int         n_exp;
        bit         halt_fit;
        int         base;
        logic [7:0] x;
        n_exp    = 0;
        halt_fit = 1'b0;
        x        = 8'h00;
        for (int i = 0; i < prog_q.size() && i < DEPTH && !halt_fit; i++) begin
            n_exp++;
            if (prog_q[i] == HALT) halt_fit = 1'b1;
        end
        send_byte(CMD_LOAD);
        chk("load_clr_error", {31'd0, bus.o_error}, 32'd0);
        chk("load_clr_done", {31'd0, bus.o_done}, 32'd0);
        base = load_count;
        for (int i = 0; i < n_exp; i++) begin
            send_word(prog_q[i]);
            for (int k = 0; k < 4; k++) x ^= prog_q[i][k*8 +: 8];
            chk("wr_strobe", {31'd0, bus.o_loading}, 32'd1);
            chk("wr_addr", bus.o_address, 32'(i * 4));
            chk("wr_data", bus.o_instruccion, prog_q[i]);
        end
        armed = halt_fit;
`ifdef LOAD_CHECKSUM_EN
        if (halt_fit) begin
            send_byte(good_sum ? x : (x ^ 8'h5A));
            armed = good_sum;
        end
`else
        if (!good_sum) armed = halt_fit;
`endif
        tick(1);
        chk("wr_count", 32'(load_count - base), 32'(n_exp));
        chk("load_error", {31'd0, bus.o_error}, {31'd0, !armed});
        chk("load_no_start", {31'd0, bus.o_start}, 32'd0);
        $display("[TB] load words=%0d written=%0d armed=%0d", prog_q.size(), n_exp, armed);
    endtask

    // Free run from ARMED for `cycles` cycles, then halt.
    task automatic do_run(input int cycles);
        send_byte(CMD_CONT);
        chk("run_start", {31'd0, bus.o_start}, 32'd1);
        tick(cycles);
        chk("run_held", {31'd0, bus.o_start}, 32'd1);
        bus.i_haltsignal = 1'b1;
        tick(1);
        bus.i_haltsignal = 1'b0;
        chk("run_stop", {31'd0, bus.o_start}, 32'd0);
        chk("run_done", {31'd0, bus.o_done}, 32'd1);
        $display("[TB] run cycles=%0d", cycles);
    endtask

    // Step from ARMED: n 'N' bytes mixed with junk, then halt coincident with 'N'.
    task automatic do_step(input int n);
        int p0, c0;
        send_byte(CMD_STEP);
        p0 = step_pulses;
        c0 = step_cycles;
        for (int k = 0; k < n; k++) begin
            send_byte(CMD_NEXT);
            tick($urandom_range(0, 2));
            send_byte(8'(8'h41 + $urandom_range(0, 10)));   // 'A'..'K', never 'N'
        end
        tick(2);
        chk("step_pulses", 32'(step_pulses - p0), 32'(n));
        chk("step_width", 32'(step_cycles - c0), 32'(n));
        bus.i_haltsignal = 1'b1;
        send_byte(CMD_NEXT);
        bus.i_haltsignal = 1'b0;
        chk("step_halt_nopulse", {31'd0, bus.o_step}, 32'd0);
        chk("step_halt_done", {31'd0, bus.o_done}, 32'd1);
        tick(2);
        chk("step_halt_count", 32'(step_pulses - p0), 32'(n));
        $display("[TB] step n=%0d", n);
    endtask

    initial begin
        bit armed;
        bus.i_rx_valid   = 1'b0;
        bus.i_rx_data    = 8'h00;
        bus.i_haltsignal = 1'b0;
        rst              = 1'b1;
        tick(3);

        // Reset state
        chk("rst_loading", {31'd0, bus.o_loading}, 32'd0);
        chk("rst_instr", bus.o_instruccion, 32'd0);
        chk("rst_addr", bus.o_address, 32'd0);
        chk("rst_start", {31'd0, bus.o_start}, 32'd0);
        chk("rst_step", {31'd0, bus.o_step}, 32'd0);
        chk("rst_done", {31'd0, bus.o_done}, 32'd0);
        chk("rst_error", {31'd0, bus.o_error}, 32'd0);

        // Reset in the middle of a word discards the partial word
        rst = 1'b0;
        send_byte(CMD_LOAD);
        send_byte(8'h12);
        send_byte(8'h34);
        do_reset();
        chk("midrst_error", {31'd0, bus.o_error}, 32'd0);
        chk("midrst_loading", {31'd0, bus.o_loading}, 32'd0);
        send_byte(CMD_LOAD);
        send_word(32'h0000_0001);
        chk("first_strobe", {31'd0, bus.o_loading}, 32'd1);
        chk("first_data", bus.o_instruccion, 32'h1);
        chk("first_addr", bus.o_address, 32'h0);
        tick(1);
        chk("strobe_one_cycle", {31'd0, bus.o_loading}, 32'd0);
        chk("data_holds", bus.o_instruccion, 32'h1);
        $display("[TB] partial-word reset then load 0x00000001");

        // Two-word program, then free run; bytes in RUN are ignored
        do_reset();
        prog_q = '{32'h2001_0005, HALT};
        run_load(1'b1, armed);
        tick(3);
        chk("armed_no_start", {31'd0, bus.o_start}, 32'd0);
        send_byte(CMD_CONT);
        chk("cont_start", {31'd0, bus.o_start}, 32'd1);
        tick(10);
        send_byte(CMD_LOAD);
        chk("run_ignores_L", {31'd0, bus.o_start}, 32'd1);
        chk("run_no_error", {31'd0, bus.o_error}, 32'd0);
        bus.i_haltsignal = 1'b1;
        tick(1);
        bus.i_haltsignal = 1'b0;
        chk("halt_stop", {31'd0, bus.o_start}, 32'd0);
        chk("halt_done", {31'd0, bus.o_done}, 32'd1);
        send_byte(8'h58);   // 'X' in IDLE
        chk("idle_bad_error", {31'd0, bus.o_error}, 32'd1);
        chk("idle_done_holds", {31'd0, bus.o_done}, 32'd1);

        // Random program, exactly three steps
        make_prog(2);
        run_load(1'b1, armed);
        do_step(3);

        // Overflow: four ordinary words fill memory without a halt
        make_prog(4);
        run_load(1'b1, armed);
        send_byte(8'h58);
        chk("ovf_error_sticky", {31'd0, bus.o_error}, 32'd1);
        send_byte(CMD_CONT);
        chk("ovf_idle_no_start", {31'd0, bus.o_start}, 32'd0);

        // Halt word in the last slot arms; a bad byte in ARMED flags but stays armed
        make_prog(DEPTH - 1);
        run_load(1'b1, armed);
        send_byte(8'h51);   // 'Q'
        chk("armed_bad_error", {31'd0, bus.o_error}, 32'd1);
        chk("armed_bad_no_start", {31'd0, bus.o_start}, 32'd0);
        do_run(4);

        // Randomised load / run / step sessions
        for (int it = 0; it < 10; it++) begin
            make_prog($urandom_range(0, 5));
            run_load(($urandom_range(0, 3) != 0), armed);
            if (armed) begin
                if ($urandom_range(0, 1) == 1) do_run($urandom_range(1, 20));
                else                           do_step($urandom_range(1, 4));
            end
        end

`ifdef LOAD_CHECKSUM_EN
        // Corrupted checksum goes back to IDLE with an error
        make_prog(1);
        run_load(1'b0, armed);
        send_byte(CMD_CONT);
        chk("badsum_no_start", {31'd0, bus.o_start}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
